// File: rtl/mod_exp_ctrl.sv
// Sequencer for left-to-right square-and-multiply modular exponentiation.
// Drives an external Montgomery multiplier and converts the final value out of Montgomery form.
module mod_exp_ctrl #(
  parameter int WIDTH = 2048,
  parameter int IDXW  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] msg_mont,
  input  logic [WIDTH-1:0] one_mont,
  input  logic [WIDTH-1:0] exp,
  input  logic [IDXW-1:0]  exp_len,
  output logic [WIDTH-1:0] mont_x,
  output logic [WIDTH-1:0] mont_y,
  output logic             mont_enable,
  input  logic             mont_finish,
  input  logic [WIDTH-1:0] mont_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SQR_ISSUE  = 3'd1,
    SQR_WAIT   = 3'd2,
    MUL_ISSUE  = 3'd3,
    MUL_WAIT   = 3'd4,
    CONV_ISSUE = 3'd5,
    CONV_WAIT  = 3'd6,
    DONE       = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IDXW-1:0]  i_q, i_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0]  ONE_I = {{(IDXW-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0]  ZERO_I = {IDXW{1'b0}};

  // State and datapath registers; all outputs come straight from these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      msg_q    <= {WIDTH{1'b0}};
      exp_q    <= {WIDTH{1'b0}};
      i_q      <= {IDXW{1'b0}};
      x_q      <= {WIDTH{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      msg_q    <= msg_d;
      exp_q    <= exp_d;
      i_q      <= i_d;
      x_q      <= x_d;
      y_q      <= y_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; each *_ISSUE leaves enable low for a cycle so every operation gets a fresh rising edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    msg_d    = msg_q;
    exp_d    = exp_q;
    i_d      = i_q;
    x_d      = x_q;
    y_d      = y_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_d   = msg_mont;
          exp_d   = exp;
          i_d     = exp_len;
          a_d     = one_mont;
          busy_d  = 1'b1;
          state_d = SQR_ISSUE;
        end else begin
          busy_d = 1'b0;
        end
      end
      SQR_ISSUE: begin
        x_d     = a_q;
        y_d     = a_q;
        en_d    = 1'b1;
        state_d = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mont_finish) begin
          a_d  = mont_result;
          en_d = 1'b0;
          if (exp_q[i_q]) begin
            state_d = MUL_ISSUE;
          end else if (i_q == ZERO_I) begin
            state_d = CONV_ISSUE;
          end else begin
            i_d     = i_q - ONE_I;
            state_d = SQR_ISSUE;
          end
        end else begin
          en_d = 1'b1;
        end
      end
      MUL_ISSUE: begin
        x_d     = a_q;
        y_d     = msg_q;
        en_d    = 1'b1;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mont_finish) begin
          a_d  = mont_result;
          en_d = 1'b0;
          if (i_q == ZERO_I) begin
            state_d = CONV_ISSUE;
          end else begin
            i_d     = i_q - ONE_I;
            state_d = SQR_ISSUE;
          end
        end else begin
          en_d = 1'b1;
        end
      end
      CONV_ISSUE: begin
        x_d     = a_q;
        y_d     = ONE_W;
        en_d    = 1'b1;
        state_d = CONV_WAIT;
      end
      CONV_WAIT: begin
        if (mont_finish) begin
          result_d = mont_result;
          en_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          en_d = 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign mont_x      = x_q;
  assign mont_y      = y_q;
  assign mont_enable = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery multiplier (n=13, R=256, R^-1=3).
module tb_mod_exp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] msg_mont = 8'd0, one_mont = 8'd0, exp = 8'd0;
  logic [2:0] exp_len = 3'd0;
  logic [7:0] mont_x, mont_y, result;
  logic [7:0] mont_result = 8'd0;
  logic       mont_enable, busy, done;
  logic       mont_finish = 1'b0;

  int checks = 0, errors = 0;
  int mult_cnt = 0, done_cycles = 0, stable_err = 0, mcyc = 0;
  logic       prev_en = 1'b0;
  logic [7:0] px = 8'd0, py = 8'd0;
  logic [7:0] last_res = 8'd0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_mont(msg_mont), .one_mont(one_mont),
    .exp(exp), .exp_len(exp_len), .mont_x(mont_x), .mont_y(mont_y),
    .mont_enable(mont_enable), .mont_finish(mont_finish), .mont_result(mont_result),
    .busy(busy), .done(done), .result(result)
  );

  // Multiplier model: finish rises 5 cycles after enable and stays up until enable drops.
  always @(posedge clk) begin
    if (!mont_enable) begin
      mcyc        <= 0;
      mont_finish <= 1'b0;
    end else if (!mont_finish) begin
      if (mcyc == 4) begin
        mont_finish <= 1'b1;
        mont_result <= 8'((int'(mont_x) * int'(mont_y) * 3) % 13);
      end
      mcyc <= mcyc + 1;
    end
  end

  // Monitor: count issued operations, operand changes while enabled, and done cycles.
  always @(negedge clk) begin
    if (mont_enable && !prev_en) mult_cnt = mult_cnt + 1;
    if (mont_enable && prev_en && (mont_x !== px || mont_y !== py)) stable_err = stable_err + 1;
    if (done) done_cycles = done_cycles + 1;
    prev_en = mont_enable;
    px = mont_x;
    py = mont_y;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] o,
                        input logic [7:0] e, input logic [2:0] l, input logic [7:0] exp_res,
                        input int exp_cnt, input bit extra_start);
    int n;
    @(negedge clk);
    msg_mont = m; one_mont = o; exp = e; exp_len = l; start = 1'b1;
    mult_cnt = 0; done_cycles = 0; stable_err = 0;
    @(negedge clk);
    start = 1'b0;
    msg_mont = 8'hA7; exp = 8'h3C; exp_len = 3'd7;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'(result), 32'(last_res));
    if (extra_start) begin
      repeat (12) @(negedge clk);
      start = 1'b1; msg_mont = 8'd3; one_mont = 8'd4;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_mults"}, 32'(mult_cnt), 32'(exp_cnt));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done_cycles), 32'd1);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_stable"}, 32'(stable_err), 32'd0);
    last_res = exp_res;
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en", 32'(mont_enable), 32'd0);
    check("rst_x", 32'(mont_x), 32'd0);
    check("rst_y", 32'(mont_y), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_op("m2e5", 8'd5, 8'd9, 8'd5, 3'd2, 8'd6, 6, 1'b0);
    run_op("e0", 8'd5, 8'd9, 8'd0, 3'd0, 8'd1, 2, 1'b0);
    run_op("eff", 8'd5, 8'd9, 8'hFF, 3'd0, 8'd2, 3, 1'b0);
    run_op("busy_start", 8'd5, 8'd9, 8'd5, 3'd2, 8'd6, 6, 1'b1);

    // Abort during the third multiplication with an asynchronous reset.
    @(negedge clk);
    msg_mont = 8'd5; one_mont = 8'd9; exp = 8'd5; exp_len = 3'd2; start = 1'b1;
    mult_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mult_cnt < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_third", 32'(mult_cnt), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en", 32'(mont_enable), 32'd0);
    check("abort_x", 32'(mont_x), 32'd0);
    check("abort_y", 32'(mont_y), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    last_res = 8'd0;
    run_op("after_rst", 8'd5, 8'd9, 8'd5, 3'd2, 8'd6, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
